// File: rtl/flit_output_scheduler.sv
// -----------------------------------------------------------------------------
// flit_output_scheduler
//   Arbitrates between a system flit channel and a normal flit channel into a
//   single registered output stage. The system channel has priority. An
//   optional starvation guard (compile macro FLIT_SCHED_STARVE_GUARD_EN) gives
//   the normal channel one turn after STARVE_LIMIT consecutive system grants
//   made while a normal flit was waiting. Every granted flit gets its checksum
//   recomputed on the way into the output register.
//
// Ports
//   nocclk                in   clock, rising edge
//   rst                   in   synchronous active-high reset
//   in_system_flit        in   system-channel flit
//   in_system_flit_valid  in   system flit offered
//   in_system_flit_ready  out  system flit accepted this cycle
//   in_normal_flit        in   normal-channel flit
//   in_normal_flit_valid  in   normal flit offered
//   in_normal_flit_ready  out  normal flit accepted this cycle
//   out_flit              out  registered granted flit, checksum recomputed
//   out_flit_valid        out  out_flit holds a flit
//   out_flit_ready        in   downstream accepts out_flit this cycle
//
// Configuration
//   FLIT_SCHED_STARVE_GUARD_EN  defined: starvation guard present
//                               undefined: strict system priority
// -----------------------------------------------------------------------------

package types;
    typedef struct packed {
        logic [7:0]  dest;
        logic [31:0] payload;
        logic [7:0]  checksum;
    } flit_t;

    // Checksum is the XOR of the header and payload bytes, seeded with 0xA5 so
    // an all-zero flit does not carry an all-zero checksum.
    function automatic flit_t calculate_checksum_comb(input flit_t f);
        flit_t r;
        r          = f;
        r.checksum = 8'hA5 ^ f.dest ^ f.payload[31:24] ^ f.payload[23:16]
                   ^ f.payload[15:8] ^ f.payload[7:0];
        return r;
    endfunction
endpackage

module flit_output_scheduler #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          nocclk,
    input  logic          rst,
    input  types::flit_t  in_system_flit,
    input  logic          in_system_flit_valid,
    output logic          in_system_flit_ready,
    input  types::flit_t  in_normal_flit,
    input  logic          in_normal_flit_valid,
    output logic          in_normal_flit_ready,
    output types::flit_t  out_flit,
    output logic          out_flit_valid,
    input  logic          out_flit_ready
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    logic         w_can_load;
    logic         w_grant_sys;
    logic         w_grant_norm;
    logic         w_sys_xfer;
    logic         w_norm_xfer;
    types::flit_t r_out_flit;
    logic         r_out_valid;

    // Output register can take a new flit when empty or draining this cycle.
    assign w_can_load = !r_out_valid || out_flit_ready;

`ifdef FLIT_SCHED_STARVE_GUARD_EN
    typedef enum logic {
        SYS_PRIO  = 1'b0,
        NORM_TURN = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_nxt;
    logic [3:0] w_starve_inc;

    // A normal turn only overrides the system channel while a normal flit is
    // actually offered; if it has gone away, the system channel keeps flowing
    // in the same cycle the FSM falls back to SYS_PRIO.
    assign w_grant_sys  = in_system_flit_valid &&
                          !(r_state == NORM_TURN && in_normal_flit_valid);
    assign w_starve_inc = r_starve_cnt + 4'd1;

    always_ff @(posedge nocclk) begin
        if (rst) begin
            r_state      <= SYS_PRIO;
            r_starve_cnt <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Normal-valid low clears the guard on every cycle, stalled or not. In a
    // stall no transfer happens, so with normal-valid high everything holds.
    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        if (!in_normal_flit_valid || w_norm_xfer) begin
            w_state_nxt  = SYS_PRIO;
            w_starve_nxt = 4'd0;
        end else if (r_state == SYS_PRIO && w_sys_xfer) begin
            w_starve_nxt = w_starve_inc;
            if (w_starve_inc == 4'(STARVE_LIMIT)) begin
                w_state_nxt = NORM_TURN;
            end
        end
    end
`else
    assign w_grant_sys = in_system_flit_valid;
`endif

    assign w_grant_norm         = in_normal_flit_valid && !w_grant_sys;
    assign in_system_flit_ready = !rst && w_can_load && w_grant_sys;
    assign in_normal_flit_ready = !rst && w_can_load && w_grant_norm;
    assign w_sys_xfer           = in_system_flit_valid && in_system_flit_ready;
    assign w_norm_xfer          = in_normal_flit_valid && in_normal_flit_ready;

    always_ff @(posedge nocclk) begin
        if (rst) begin
            r_out_flit  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_sys_xfer) begin
            r_out_flit  <= types::calculate_checksum_comb(in_system_flit);
            r_out_valid <= 1'b1;
        end else if (w_norm_xfer) begin
            r_out_flit  <= types::calculate_checksum_comb(in_normal_flit);
            r_out_valid <= 1'b1;
        end else if (out_flit_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_flit       = r_out_flit;
    assign out_flit_valid = r_out_valid;

endmodule

// File: tb/tb_flit_output_scheduler.sv
module tb_flit_output_scheduler;
    localparam int LIMIT = 4;

    logic         nocclk = 1'b0;
    logic         rst;
    types::flit_t s_flit, n_flit, o_flit;
    logic         sv, nv, s_rdy, n_rdy, o_vld, o_rdy;

    always #5 nocclk = ~nocclk;

    flit_output_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
        .nocclk               (nocclk),
        .rst                  (rst),
        .in_system_flit       (s_flit),
        .in_system_flit_valid (sv),
        .in_system_flit_ready (s_rdy),
        .in_normal_flit       (n_flit),
        .in_normal_flit_valid (nv),
        .in_normal_flit_ready (n_rdy),
        .out_flit             (o_flit),
        .out_flit_valid       (o_vld),
        .out_flit_ready       (o_rdy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference checksum: seed 0xA5 XORed with every header and payload byte.
    function automatic types::flit_t ref_csum(input types::flit_t f);
        types::flit_t r;
        logic [7:0]   c;
        r = f;
        c = 8'hA5 ^ f.dest;
        for (int b = 0; b < 4; b++) c = c ^ f.payload[8*b +: 8];
        r.checksum = c;
        return r;
    endfunction

    // System flits carry dest[7]=1, normal flits dest[7]=0; checksum is junk.
    function automatic types::flit_t rnd_flit(input bit is_sys);
        types::flit_t f;
        f.dest     = {is_sys, 7'($urandom_range(0, 127))};
        f.payload  = $urandom;
        f.checksum = 8'($urandom_range(0, 255));
        return f;
    endfunction

    // Behavioural model: the output slot, and how many system grants in a row
    // have gone by while a normal flit was waiting.
    bit           m_vld;
    types::flit_t m_flit;
    int           m_starved;
    bit           m_sx, m_nx;
    bit           out_q[$];   // dest[7] of each delivered flit
    bit           gnt_q[$];   // 1 = system accepted, 0 = normal accepted
    int           n_rdy_hi;

    always @(negedge nocclk) begin
        bit turn, sg, ng, cl, esr, enr;
`ifdef FLIT_SCHED_STARVE_GUARD_EN
        turn = nv && (m_starved >= LIMIT);
`else
        turn = 1'b0;
`endif
        sg  = sv && !turn;
        ng  = nv && !sg;
        cl  = !m_vld || o_rdy;
        esr = !rst && cl && sg;
        enr = !rst && cl && ng;

        check("out_valid", 64'(o_vld), 64'(m_vld));
        if (m_vld) check("out_flit", 64'(o_flit), 64'(m_flit));
        check("sys_ready", 64'(s_rdy), 64'(esr));
        check("norm_ready", 64'(n_rdy), 64'(enr));

        if (n_rdy) n_rdy_hi++;
        if (!rst && o_vld && o_rdy) out_q.push_back(o_flit.dest[7]);
        if (!rst && sv && s_rdy) gnt_q.push_back(1'b1);
        if (!rst && nv && n_rdy) gnt_q.push_back(1'b0);

        if (rst) begin
            m_vld = 0; m_flit = '0; m_starved = 0; m_sx = 0; m_nx = 0;
        end else begin
            m_sx = sv && esr;
            m_nx = nv && enr;
            if (m_sx)       begin m_flit = ref_csum(s_flit); m_vld = 1; end
            else if (m_nx)  begin m_flit = ref_csum(n_flit); m_vld = 1; end
            else if (o_rdy) m_vld = 0;
            if (!nv || m_nx) m_starved = 0;
            else if (m_sx && m_starved < 1000) m_starved++;
        end
    end

    // One clock: wait for the edge, then present the next inputs. A system flit
    // stays put until it transfers; a normal flit may be withdrawn.
    task automatic cyc(input bit ws, input bit wn, input bit ordy);
        @(posedge nocclk); #1;
        if (!(sv && !m_sx)) begin
            sv = ws;
            if (ws) s_flit = rnd_flit(1'b1);
        end
        if (!(nv && !m_nx && wn)) begin
            nv = wn;
            if (wn) n_flit = rnd_flit(1'b0);
        end
        o_rdy = ordy;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        types::flit_t cap, bad, want;
        logic [9:0]   seq, exp_seq;
        logic [4:0]   gseq;
        int           guard;

        // Reset held two cycles with both channels offering.
        rst = 1'b1; o_rdy = 1'b1;
        s_flit = rnd_flit(1'b1); n_flit = rnd_flit(1'b0);
        sv = 1'b1; nv = 1'b1;
        @(posedge nocclk); @(posedge nocclk); #1;
        rst = 1'b0;
        @(negedge nocclk);
        check("rst_release_valid", 64'(o_vld), 64'd0);
        check("rst_flit_zero", 64'(o_flit), 64'd0);
        cyc(1'b1, 1'b1, 1'b1);
        @(negedge nocclk);
        check("first_out_valid", 64'(o_vld), 64'd1);
        check("first_out_is_sys", 64'(o_flit.dest[7]), 64'd1);

        // Corrupted checksum is replaced with the recomputed one.
        drain();
        bad = '{dest: 8'h12, payload: 32'h3456_789A, checksum: 8'hFF};
        want = '{dest: 8'h12, payload: 32'h3456_789A, checksum: 8'h37};
        @(posedge nocclk); #1;
        s_flit = bad; sv = 1'b1; nv = 1'b0; o_rdy = 1'b1;
        @(posedge nocclk); #1;
        sv = 1'b0;
        @(negedge nocclk);
        check("csum_valid", 64'(o_vld), 64'd1);
        check("csum_flit", 64'(o_flit), 64'(want));

        // Both channels saturated, output always ready.
        drain();
        out_q.delete(); n_rdy_hi = 0;
        guard = 0;
        while (out_q.size() < 10 && guard < 30) begin
            cyc(1'b1, 1'b1, 1'b1);
            guard++;
        end
        check("sat_timeout", 64'(out_q.size() >= 10), 64'd1);
        seq = '0;
        for (int i = 0; i < 10 && i < out_q.size(); i++) seq = {seq[8:0], out_q[i]};
`ifdef FLIT_SCHED_STARVE_GUARD_EN
        exp_seq = 10'b11110_11110;
        check("sat_order", 64'(seq), 64'(exp_seq));
        check("sat_one_per_cycle", 64'(guard <= 12), 64'd1);
`else
        exp_seq = 10'b11111_11111;
        check("sat_order", 64'(seq), 64'(exp_seq));
        check("sat_norm_never_ready", 64'(n_rdy_hi), 64'd0);
`endif

        // Normal flit alone against a stalled output.
        drain();
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        @(negedge nocclk);
        cap = o_flit;
        check("stall_captured", 64'(o_vld), 64'd1);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            @(negedge nocclk);
            check("stall_hold_flit", 64'(o_flit), 64'(cap));
            check("stall_no_accept", 64'(n_rdy), 64'd0);
        end
        cyc(1'b0, 1'b0, 1'b1);
        @(negedge nocclk);
        check("stall_deliver_valid", 64'(o_vld), 64'd1);
        check("stall_deliver_flit", 64'(o_flit), 64'(cap));

        // Reset discards a held output flit.
        drain();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        @(posedge nocclk); #1;
        rst = 1'b1;
        @(posedge nocclk); #1;
        rst = 1'b0;
        @(negedge nocclk);
        check("rst_discard", 64'(o_vld), 64'd0);

        // Three starved grants, normal withdrawn one cycle: count restarts.
        drain();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        gnt_q.delete();
        guard = 0;
        while (gnt_q.size() < 5 && guard < 30) begin
            cyc(1'b1, 1'b1, 1'b1);
            guard++;
        end
        check("restart_timeout", 64'(gnt_q.size() >= 5), 64'd1);
        gseq = '0;
        for (int i = 0; i < 5 && i < gnt_q.size(); i++) gseq = {gseq[3:0], gnt_q[i]};
`ifdef FLIT_SCHED_STARVE_GUARD_EN
        check("restart_order", 64'(gseq), 64'(5'b11110));
`else
        check("restart_order", 64'(gseq), 64'(5'b11111));
`endif

        // Randomized traffic, backpressure and occasional reset.
        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 199) == 0);
        end
        @(posedge nocclk); #1;
        rst = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
